// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - next-PC selection, deferred redirect and IF/ID register for the MIPS fetch stage
// Optional FETCH_PERF_EN adds FETCH_CNT/STALL_CNT performance counters.
module fetch_stage #(
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] PC_OUT,
  input  logic [31:0] INSTR_IN,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic [31:0] PC_IN,
  output logic        PC_CTRL,
  output logic [31:0] IF_ID_INSTR,
  output logic [31:0] IF_ID_PC4,
  output logic        IF_ID_VALID,
  output logic        MISALIGN
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] FETCH_CNT,
  output logic [31:0] STALL_CNT
`endif
);

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pend_pc;
  logic [31:0] pend_pc_nxt;
  logic [31:0] redirect_tgt;
  logic [31:0] pc_inc;
  logic        flush;
  logic        load;

  assign redirect_tgt = {REDIRECT_PC[31:2], 2'b00};
  assign pc_inc       = PC_OUT + PC_STEP;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= RUN;
      pend_pc <= 32'h0;
    end else begin
      state   <= state_nxt;
      pend_pc <= pend_pc_nxt;
    end
  end

  // Redirect beats pending target beats sequential fetch; a flush always wins over stall.
  always_comb begin
    state_nxt   = state;
    pend_pc_nxt = pend_pc;
    PC_IN       = pc_inc;
    PC_CTRL     = RESET_N & ~STALL;
    flush       = 1'b0;
    load        = 1'b0;
    if (REDIRECT) begin
      PC_IN = redirect_tgt;
      flush = 1'b1;
      if (STALL) begin
        state_nxt   = PEND;
        pend_pc_nxt = redirect_tgt;
      end else begin
        state_nxt = RUN;
      end
    end else if (state == PEND) begin
      PC_IN = pend_pc;
      if (!STALL) begin
        flush     = 1'b1;
        state_nxt = RUN;
      end
    end else begin
      load = ~STALL;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      IF_ID_INSTR <= NOP_WORD;
      IF_ID_PC4   <= 32'h0;
      IF_ID_VALID <= 1'b0;
      MISALIGN    <= 1'b0;
    end else begin
      if (flush) begin
        IF_ID_INSTR <= NOP_WORD;
        IF_ID_PC4   <= 32'h0;
        IF_ID_VALID <= 1'b0;
      end else if (load) begin
        IF_ID_INSTR <= INSTR_IN;
        IF_ID_PC4   <= pc_inc;
        IF_ID_VALID <= 1'b1;
      end
      MISALIGN <= REDIRECT & (|REDIRECT_PC[1:0]);
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      FETCH_CNT <= 32'h0;
      STALL_CNT <= 32'h0;
    end else begin
      if (load)  FETCH_CNT <= FETCH_CNT + 32'd1;
      if (STALL) STALL_CNT <= STALL_CNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized self-checking bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [31:0] PC_OUT;
  logic [31:0] INSTR_IN;
  logic        STALL;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic [31:0] PC_IN;
  logic        PC_CTRL;
  logic [31:0] IF_ID_INSTR;
  logic [31:0] IF_ID_PC4;
  logic        IF_ID_VALID;
  logic        MISALIGN;
`ifdef FETCH_PERF_EN
  logic [31:0] FETCH_CNT;
  logic [31:0] STALL_CNT;
`endif

  fetch_stage dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .PC_OUT     (PC_OUT),
    .INSTR_IN   (INSTR_IN),
    .STALL      (STALL),
    .REDIRECT   (REDIRECT),
    .REDIRECT_PC(REDIRECT_PC),
    .PC_IN      (PC_IN),
    .PC_CTRL    (PC_CTRL),
    .IF_ID_INSTR(IF_ID_INSTR),
    .IF_ID_PC4  (IF_ID_PC4),
    .IF_ID_VALID(IF_ID_VALID),
    .MISALIGN   (MISALIGN)
`ifdef FETCH_PERF_EN
    ,
    .FETCH_CNT  (FETCH_CNT),
    .STALL_CNT  (STALL_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: IF/ID contents, at most one pending target, the PC register itself.
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic        m_mis;
  logic [31:0] pend_q[$];
  logic [31:0] pc_reg;
  logic [31:0] m_fetch_cnt;
  logic [31:0] m_stall_cnt;
  logic [31:0] last_pc_in;
  logic        last_pc_ctrl;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_instr     = NOP;
    m_pc4       = 32'h0;
    m_valid     = 1'b0;
    m_mis       = 1'b0;
    m_fetch_cnt = 32'h0;
    m_stall_cnt = 32'h0;
    pend_q.delete();
  endtask

  task automatic check_regs();
    check_eq("if_id_instr", IF_ID_INSTR, m_instr);
    check_eq("if_id_pc4", IF_ID_PC4, m_pc4);
    check_eq("if_id_valid", {31'b0, IF_ID_VALID}, {31'b0, m_valid});
    check_eq("misalign", {31'b0, MISALIGN}, {31'b0, m_mis});
`ifdef FETCH_PERF_EN
    check_eq("fetch_cnt", FETCH_CNT, m_fetch_cnt);
    check_eq("stall_cnt", STALL_CNT, m_stall_cnt);
`endif
  endtask

  // One clock: drive, check combinational next-PC, clock, advance model, check registers.
  task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc, input logic [31:0] ins);
    logic [31:0] tgt;
    logic [31:0] exp_pc;
    PC_OUT      = pc_reg;
    STALL       = st;
    REDIRECT    = rd;
    REDIRECT_PC = rpc;
    INSTR_IN    = ins;
    tgt    = {rpc[31:2], 2'b00};
    exp_pc = rd ? tgt : (pend_q.size() != 0 ? pend_q[0] : pc_reg + 32'd4);
    #1;
    last_pc_in   = PC_IN;
    last_pc_ctrl = PC_CTRL;
    check_eq("pc_in", PC_IN, exp_pc);
    check_eq("pc_ctrl", {31'b0, PC_CTRL}, {31'b0, ~st});
    @(posedge CLK);
    if (st) m_stall_cnt = m_stall_cnt + 32'd1;
    if (rd) begin
      m_instr = NOP; m_pc4 = 32'h0; m_valid = 1'b0;
      pend_q.delete();
      if (st) pend_q.push_back(tgt);
    end else if (st) begin
      // hold everything
    end else if (pend_q.size() != 0) begin
      m_instr = NOP; m_pc4 = 32'h0; m_valid = 1'b0;
      pend_q.delete();
    end else begin
      m_instr = ins; m_pc4 = pc_reg + 32'd4; m_valid = 1'b1;
      m_fetch_cnt = m_fetch_cnt + 32'd1;
    end
    m_mis = rd && (rpc[1:0] != 2'b00);
    if (!st) pc_reg = exp_pc;
    #1;
    check_regs();
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic apply_reset();
    #2;
    STALL    = 1'b0;
    REDIRECT = 1'b0;
    RESET_N  = 1'b0;
    #1;
    model_reset();
    check_regs();
    check_eq("pc_ctrl_rst", {31'b0, PC_CTRL}, 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    pc_reg  = 32'h0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b0; STALL = 1'b0; REDIRECT = 1'b0;
    REDIRECT_PC = 32'h0; INSTR_IN = 32'h0; PC_OUT = 32'h0;
    pc_reg = 32'h0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_regs();
    check_eq("pc_ctrl_rst", {31'b0, PC_CTRL}, 32'h0);
    RESET_N = 1'b1;

    // Reset then run
    cycle(1'b0, 1'b0, 32'h0, 32'h2008_0005);
    check_eq("run_pc_in", last_pc_in, 32'h4);
    check_eq("run_instr", IF_ID_INSTR, 32'h2008_0005);
    check_eq("run_pc4", IF_ID_PC4, 32'h4);

    // Stall at PC 8 for three cycles
    cycle(1'b0, 1'b0, 32'h0, 32'h1111_1111);
    pc_reg = 32'h8;
    repeat (3) begin
      cycle(1'b1, 1'b0, 32'h0, $urandom);
      check_eq("stall_ctrl", {31'b0, last_pc_ctrl}, 32'h0);
    end
    cycle(1'b0, 1'b0, 32'h0, 32'h2222_2222);
    check_eq("stall_resume_pc4", IF_ID_PC4, 32'hC);

    // Redirect without stall
    cycle(1'b0, 1'b1, 32'h40, $urandom);
    check_eq("redir_pc_in", last_pc_in, 32'h40);
    check_eq("redir_valid", {31'b0, IF_ID_VALID}, 32'h0);
    check_eq("redir_instr", IF_ID_INSTR, 32'h0);

    // Redirect under stall, released two cycles later
    cycle(1'b0, 1'b0, 32'h0, 32'h3333_3333);
    cycle(1'b1, 1'b1, 32'h100, $urandom);
    check_eq("pend_flush_valid", {31'b0, IF_ID_VALID}, 32'h0);
    cycle(1'b1, 1'b0, 32'h0, $urandom);
    cycle(1'b1, 1'b0, 32'h0, $urandom);
    cycle(1'b0, 1'b0, 32'h0, $urandom);
    check_eq("pend_release_pc", last_pc_in, 32'h100);
    check_eq("pend_release_ctrl", {31'b0, last_pc_ctrl}, 32'h1);
    cycle(1'b0, 1'b0, 32'h0, 32'h4444_4444);
    check_eq("pend_after_pc4", IF_ID_PC4, 32'h104);

    // Misaligned target, then PC wrap
    cycle(1'b0, 1'b1, 32'h43, $urandom);
    check_eq("mis_pc_in", last_pc_in, 32'h40);
    check_eq("mis_pulse", {31'b0, MISALIGN}, 32'h1);
    cycle(1'b0, 1'b0, 32'h0, $urandom);
    check_eq("mis_clear", {31'b0, MISALIGN}, 32'h0);
    pc_reg = 32'hFFFF_FFFC;
    cycle(1'b0, 1'b0, 32'h0, $urandom);
    check_eq("wrap_pc_in", last_pc_in, 32'h0);

    // Reset while a redirect is pending
    cycle(1'b1, 1'b1, 32'h200, $urandom);
    cycle(1'b1, 1'b0, 32'h0, $urandom);
    apply_reset();
    cycle(1'b0, 1'b0, 32'h0, $urandom);
    check_eq("rst_pend_pc_in", last_pc_in, 32'h4);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) apply_reset();
      if ($urandom_range(0, 49) == 0) pc_reg = 32'hFFFF_FFFC;
      cycle($urandom_range(0, 9) < 4, $urandom_range(0, 99) < 15, $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch control and IF/ID pipeline register for the MIPS core. Computes the next program counter (`PC+4` or a redirect target) and its load enable for the PC register, captures the fetched instruction with its `PC+4` into the IF/ID register, and applies stall, flush and deferred-redirect handling. It sits directly around the PC register: it consumes `PC_OUT` and drives `PC_IN`/`PC_CTRL`.

## Interface
Parameters:
- `PC_STEP`, default 4: fetch increment in bytes.
- `NOP_WORD`, default 32'h00000000: instruction word inserted as a bubble (`sll $0,$0,0`).

Ports:
- `CLK` input 1: clock; all state changes on the rising edge.
- `RESET_N` input 1: asynchronous, active-low reset.
- `PC_OUT` input 32: current PC from the PC register.
- `INSTR_IN` input 32: instruction memory read data for `PC_OUT`, valid in the same cycle.
- `STALL` input 1: hazard unit hold of IF and ID.
- `REDIRECT` input 1: branch/jump taken; one-cycle pulse.
- `REDIRECT_PC` input 32: redirect target, qualified by `REDIRECT`.
- `PC_IN` output 32: next PC to the PC register.
- `PC_CTRL` output 1: PC load enable.
- `IF_ID_INSTR` output 32: registered instruction.
- `IF_ID_PC4` output 32: registered `PC_OUT+PC_STEP`.
- `IF_ID_VALID` output 1: IF/ID holds a real instruction.
- `MISALIGN` output 1: registered pulse, redirect target had bits [1:0] ≠ 0.

## Operation
- **States:**
  - `RUN`: no pending redirect.
  - `PEND`: a redirect is held in `pend_pc` waiting for `STALL` to drop.
- **Next PC (combinational):**
  - Priority is `REDIRECT` (current cycle), then `pend_pc` (`PEND`), then `PC_OUT+PC_STEP`.
  - Redirect targets have bits [1:0] forced to 00.
  - Addition is modulo 2^32: `32'hFFFFFFFC + 4 = 0`.
- **`PC_CTRL`:** equals `~STALL`. It is 0 while `RESET_N` is low.
- **Normal fetch** (`STALL=0`, no redirect, `RUN`):
  - IF/ID loads `INSTR_IN`, `PC_OUT+PC_STEP`, and `VALID=1`.
- **Stall** (`STALL=1`, no redirect): IF/ID and PC hold.
- **Redirect with `STALL=0`:**
  - PC loads the target.
  - IF/ID loads the bubble: `NOP_WORD`, `PC4=0`, `VALID=0`.
  - State goes to `RUN`.
- **Redirect with `STALL=1`:**
  - `pend_pc` takes the target; state goes to `PEND`.
  - IF/ID is flushed to the bubble, because flush overrides stall.
  - PC holds.
- **`PEND` with `STALL=0`:**
  - PC loads `pend_pc`.
  - IF/ID loads the bubble, since the instruction at the stale PC is wrong-path.
  - State goes to `RUN`.
- **`PEND` with `STALL=1`:** PC holds. A new `REDIRECT` overwrites `pend_pc`.
- **`MISALIGN`:** set for one cycle after any accepted `REDIRECT` whose `REDIRECT_PC[1:0]≠0`.
- **Reset (asynchronous, any time):**
  - State `RUN`, `pend_pc=0`.
  - `IF_ID_INSTR=NOP_WORD`, `IF_ID_PC4=0`, `IF_ID_VALID=0`, `MISALIGN=0`.
  - Any pending redirect is discarded.

## Timing
- Fetch-to-IF/ID latency is 1 cycle: the instruction at `PC_OUT` in cycle n appears on `IF_ID_*` after edge n+1.
- Redirect penalty is 1 bubble.
- Deferred redirect: the PC is updated on the first edge with `STALL=0`.
- The first cycle after `RESET_N` rises fetches address 0, with `PC_CTRL=1` unless stalled.
- `PC_IN` and `PC_CTRL` are combinational from the inputs and state. No combinational path exists from `INSTR_IN` to `PC_IN`.

## Configuration
- `FETCH_PERF_EN` defined: adds two 32-bit outputs.
  - `FETCH_CNT` increments on each cycle IF/ID loads `VALID=1`.
  - `STALL_CNT` increments on each cycle with `STALL=1`.
  - Both wrap at 2^32 and reset to 0.
- `FETCH_PERF_EN` undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- **Reset then run:**
  - Stimulus: hold `RESET_N=0`, release, set `INSTR_IN=32'h20080005` at PC 0.
  - Response: `PC_IN=4`, `PC_CTRL=1`; after the edge `IF_ID_INSTR=32'h20080005`, `IF_ID_PC4=4`, `VALID=1`.
- **Stall:**
  - Stimulus: `PC_OUT=8`, `STALL=1` for 3 cycles.
  - Response: `PC_CTRL=0`, IF/ID unchanged for all 3 cycles; fetch resumes with `IF_ID_PC4=12`.
- **Redirect, no stall:**
  - Stimulus: `REDIRECT=1`, `REDIRECT_PC=32'h00000040`.
  - Response: `PC_IN=32'h40`, `PC_CTRL=1`; next cycle `IF_ID_VALID=0`, `IF_ID_INSTR=0`.
- **Redirect under stall:**
  - Stimulus: `STALL=1`, pulse `REDIRECT` with `32'h100`, hold `STALL` for 2 more cycles, then release.
  - Response: IF/ID flushed immediately; `PC_IN=32'h100` with `PC_CTRL=1` on the release cycle; state returns to `RUN`.
- **Misalign and wrap:**
  - Stimulus: `REDIRECT_PC=32'h00000043`, then separately `PC_OUT=32'hFFFFFFFC`.
  - Response: first case gives `PC_IN=32'h40` and a one-cycle `MISALIGN` pulse; second case gives `PC_IN=0`.
- **Reset mid-pend:**
  - Stimulus: pull `RESET_N` low while in `PEND`.
  - Response: all outputs return to reset values; the pending target is never loaded.
